ber_window_monitor: RTL and testbench

- Downstream of the test controller. Consumes the per-word compare result (bit errors in the word, bits compared) on each valid strobe.
- Runs a sync/lock state machine over that stream and accumulates errors and bits over fixed-size measurement windows.
- Publishes per-window results, saturating running totals, and a loss-of-lock alarm for the BERT readout.

---
 rtl/ber_pkg.sv | 20 ++
 rtl/ber_window_monitor_if.sv | 9 +
 rtl/ber_sat_counter.sv | 25 ++
 rtl/ber_window_monitor.sv | 114 +++++++++++
 tb/tb_ber_window_monitor.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ber_pkg.sv
// Shared types and helpers for the BER window monitor: lock states, PRBS word sizes
// and a saturating adder used by every counter in the block.
package ber_pkg;

  typedef enum logic [1:0] {HUNT, LOCKED, LOST} ber_state_e;

  localparam logic [3:0] PRBS7_WORD_BITS  = 4'd8;
  localparam logic [3:0] PRBS13_WORD_BITS = 4'd13;

  // a + b clamped to the all-ones value of a w-bit counter (w <= 63)
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] s;
    logic [64:0] mx;
    s  = {1'b0, a} + {1'b0, b};
    mx = (65'd1 << w) - 65'd1;
    return (s > mx) ? mx[63:0] : s[63:0];
  endfunction

endpackage

// File: rtl/ber_window_monitor_if.sv
// Per-word compare result stream from the test controller into the BER monitor.
interface ber_window_monitor_if;
  logic       err_valid;
  logic [3:0] err_bits;
  logic [3:0] word_bits;

  modport master (output err_valid, output err_bits, output word_bits);
  modport slave  (input  err_valid, input  err_bits, input  word_bits);
endinterface

// File: rtl/ber_sat_counter.sv
// Accumulating counter that sticks at all-ones; q_nxt exposes the would-be value so
// the owner can make decisions on the count including the current increment.
module ber_sat_counter
  import ber_pkg::*;
#(
  parameter int W     = 32,
  parameter int ADD_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [ADD_W-1:0] add,
  output logic [W-1:0]     q,
  output logic [W-1:0]     q_nxt
);

  always_comb q_nxt = W'(sat_add(64'(q), 64'(add), W));

  always_ff @(posedge clock) begin
    if (reset || clr) q <= '0;
    else if (en)      q <= q_nxt;
  end

endmodule

// File: rtl/ber_window_monitor.sv
// BER window monitor: HUNT/LOCKED/LOST sync machine, fixed-size measurement windows,
// saturating totals and sticky loss alarm. Optional peak tracking: BER_PEAK_TRACK_EN.
module ber_window_monitor
  import ber_pkg::*;
#(
  parameter int WINDOW_BITS = 4096,
  parameter int CNT_W       = 32,
  parameter int WERR_W      = 16,
  parameter int SYNC_WORDS  = 4,
  parameter int LOSS_THRESH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  ber_window_monitor_if.slave  word,
  input  logic                 clear,
  output logic                 lock,
  output logic                 alarm,
  output logic                 result_valid,
  output logic [WERR_W-1:0]    window_errors,
  output logic [CNT_W-1:0]     total_errors,
  output logic [CNT_W-1:0]     total_bits,
  output logic [WERR_W-1:0]    peak_errors
);

  localparam int WIN_W  = $clog2(WINDOW_BITS + 14);
  localparam int SYNC_W = $clog2(SYNC_WORDS + 1);

  ber_state_e        state;
  logic [SYNC_W-1:0] sync_cnt;
  logic [WIN_W-1:0]  win_bits, win_bits_nxt;
  logic [WERR_W-1:0] win_err, win_err_nxt;
  logic [CNT_W-1:0]  tot_err_nxt, tot_bits_nxt;
  logic [3:0]        wb, eb;
  logic              acc, win_close, loss, win_clr;

  always_comb begin
    wb           = (word.word_bits == PRBS7_WORD_BITS) ? PRBS7_WORD_BITS : PRBS13_WORD_BITS;
    eb           = (word.err_bits > wb) ? wb : word.err_bits;
    // clear drops a word arriving in the same cycle
    acc          = word.err_valid && (state == LOCKED) && !clear;
    win_bits_nxt = win_bits + WIN_W'(wb);
    win_close    = acc && (win_bits_nxt >= WIN_W'(WINDOW_BITS));
    loss         = acc && (32'(win_err_nxt) >= 32'(LOSS_THRESH));
    win_clr      = clear || win_close || (state == LOST);
  end

  ber_sat_counter #(.W(WERR_W), .ADD_W(4)) u_win_err (
    .clock(clock), .reset(reset), .clr(win_clr), .en(acc), .add(eb),
    .q(win_err), .q_nxt(win_err_nxt)
  );

  ber_sat_counter #(.W(CNT_W), .ADD_W(4)) u_tot_err (
    .clock(clock), .reset(reset), .clr(clear), .en(acc), .add(eb),
    .q(total_errors), .q_nxt(tot_err_nxt)
  );

  ber_sat_counter #(.W(CNT_W), .ADD_W(4)) u_tot_bits (
    .clock(clock), .reset(reset), .clr(clear), .en(acc), .add(wb),
    .q(total_bits), .q_nxt(tot_bits_nxt)
  );

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state         <= HUNT;
      sync_cnt      <= '0;
      win_bits      <= '0;
      lock          <= 1'b0;
      alarm         <= 1'b0;
      result_valid  <= 1'b0;
      window_errors <= '0;
    end else begin
      result_valid <= win_close;
      if (win_close) window_errors <= win_err_nxt;
      case (state)
        HUNT: if (word.err_valid) begin
          if (eb != 4'd0) begin
            sync_cnt <= '0;
          end else if (sync_cnt == SYNC_W'(SYNC_WORDS - 1)) begin
            // the locking word itself is not accumulated
            state    <= LOCKED;
            lock     <= 1'b1;
            sync_cnt <= '0;
          end else begin
            sync_cnt <= sync_cnt + 1'b1;
          end
        end
        LOCKED: if (word.err_valid) begin
          win_bits <= win_close ? '0 : win_bits_nxt;
          if (loss) begin
            state <= LOST;
            lock  <= 1'b0;
            alarm <= 1'b1;
          end
        end
        LOST: begin
          win_bits <= '0;
          sync_cnt <= '0;
          state    <= HUNT;
        end
        default: state <= HUNT;
      endcase
    end
  end

`ifdef BER_PEAK_TRACK_EN
  always_ff @(posedge clock) begin
    if (reset || clear)                               peak_errors <= '0;
    else if (win_close && win_err_nxt > peak_errors) peak_errors <= win_err_nxt;
  end
`else
  assign peak_errors = '0;
`endif

endmodule

// File: tb/tb_ber_window_monitor.sv
// Directed bench for ber_window_monitor: lock, windows, peak, clear, clamp, loss and
// saturation (second instance with 8-bit totals and a 16-bit window).
module tb_ber_window_monitor;

`ifdef BER_PEAK_TRACK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, clear;
  always #5 clock = ~clock;

  ber_window_monitor_if ifc ();
  ber_window_monitor_if ifs ();

  logic        lock, alarm, rv;
  logic [15:0] we, pk;
  logic [31:0] te, tb;
  logic        s_lock, s_alarm, s_rv;
  logic [15:0] s_we, s_pk;
  logic [7:0]  s_te, s_tb;

  int n_chk = 0;
  int n_err = 0;

  ber_window_monitor u_dut (
    .clock(clock), .reset(reset), .word(ifc), .clear(clear),
    .lock(lock), .alarm(alarm), .result_valid(rv), .window_errors(we),
    .total_errors(te), .total_bits(tb), .peak_errors(pk)
  );

  ber_window_monitor #(.WINDOW_BITS(16), .CNT_W(8)) u_sat (
    .clock(clock), .reset(reset), .word(ifs), .clear(clear),
    .lock(s_lock), .alarm(s_alarm), .result_valid(s_rv), .window_errors(s_we),
    .total_errors(s_te), .total_bits(s_tb), .peak_errors(s_pk)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drive one word from a falling edge; returns on the next falling edge
  task automatic word(input int e, input int w);
    ifc.err_valid = 1'b1;
    ifc.err_bits  = 4'(e);
    ifc.word_bits = 4'(w);
    @(negedge clock);
    ifc.err_valid = 1'b0;
  endtask

  task automatic word_s(input int e, input int w);
    ifs.err_valid = 1'b1;
    ifs.err_bits  = 4'(e);
    ifs.word_bits = 4'(w);
    @(negedge clock);
    ifs.err_valid = 1'b0;
  endtask

  task automatic relock13();
    for (int i = 0; i < 4; i++) word(0, 13);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  // 512 8-bit words: first k carry e errors, the closing word carries last_e
  task automatic run_window(input int k, input int e, input int last_e);
    int early;
    early = 0;
    for (int i = 0; i < 511; i++) begin
      word((i < k) ? e : 0, 8);
      if (rv) early++;
    end
    chk("rv_before_close", early, 0);
    word(last_e, 8);
    chk("rv_at_close", rv, 1);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0;
    ifc.err_valid = 1'b0; ifc.err_bits = '0; ifc.word_bits = 4'd8;
    ifs.err_valid = 1'b0; ifs.err_bits = '0; ifs.word_bits = 4'd8;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    chk("rst_lock", lock, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_rv", rv, 0);
    chk("rst_we", we, 0);
    chk("rst_te", te, 0);
    chk("rst_tb", tb, 0);
    chk("rst_peak", pk, 0);

    // acquire lock
    for (int i = 0; i < 3; i++) word(0, 13);
    chk("lock_after3", lock, 0);
    word(0, 13);
    chk("lock_after4", lock, 1);
    chk("lock_te", te, 0);
    chk("lock_tb", tb, 0);

    // clean window of 512 PRBS-7 words
    run_window(0, 0, 0);
    chk("win0_we", we, 0);
    chk("win0_tb", tb, 4096);
    chk("win0_te", te, 0);
    @(negedge clock);
    chk("rv_one_cycle", rv, 0);

    // windows with 3, 10, 7 errors
    run_window(3, 1, 0);
    chk("win3_we", we, 3);
    chk("win3_peak", pk, PK ? 3 : 0);
    run_window(10, 1, 0);
    chk("win10_we", we, 10);
    chk("win10_peak", pk, PK ? 10 : 0);
    run_window(7, 1, 0);
    chk("win7_we", we, 7);
    chk("win7_peak", pk, PK ? 10 : 0);
    chk("win_te", te, 20);
    chk("win_tb", tb, 16384);
    chk("win_lock", lock, 1);

    // clear mid-window together with an errored word
    for (int i = 0; i < 10; i++) word(0, 8);
    clear = 1'b1;
    word(5, 8);
    clear = 1'b0;
    chk("clr_lock", lock, 0);
    chk("clr_alarm", alarm, 0);
    chk("clr_we", we, 0);
    chk("clr_te", te, 0);
    chk("clr_tb", tb, 0);
    chk("clr_peak", pk, 0);
    relock13();
    chk("clr_relock", lock, 1);
    word(0, 8);
    chk("clr_post_tb", tb, 8);
    chk("clr_post_te", te, 0);

    // clamping of err_bits and word_bits
    word(15, 8);
    chk("clamp_te", te, 8);
    chk("clamp_tb", tb, 16);
    word(2, 5);
    chk("wb_other_te", te, 10);
    chk("wb_other_tb", tb, 29);

    // loss: 13-bit words with one error each reach 64 on word 64
    pulse_clear();
    relock13();
    for (int i = 0; i < 63; i++) word(1, 13);
    chk("loss_lock63", lock, 1);
    chk("loss_te63", te, 63);
    word(1, 13);
    chk("loss_lock", lock, 0);
    chk("loss_alarm", alarm, 1);
    chk("loss_rv", rv, 0);
    chk("loss_te", te, 64);
    chk("loss_tb", tb, 832);
    word(0, 8);  // arrives in LOST, ignored
    chk("lost_tb", tb, 832);
    word(0, 13); word(0, 13); word(1, 13);
    word(0, 13); word(0, 13); word(0, 13);
    chk("hunt_err_restart", lock, 0);
    word(0, 13);
    chk("relock_lock", lock, 1);
    chk("relock_alarm", alarm, 1);
    chk("relock_te", te, 64);
    chk("relock_tb", tb, 832);

    // closing word also crosses the loss threshold
    run_window(7, 8, 8);
    chk("combo_we", we, 64);
    chk("combo_lock", lock, 0);
    chk("combo_alarm", alarm, 1);
    chk("combo_te", te, 128);
    chk("combo_tb", tb, 4928);
    chk("combo_peak", pk, PK ? 64 : 0);
    word(0, 8);
    chk("combo_lost_tb", tb, 4928);
    chk("combo_rv_drop", rv, 0);

    // saturation of 8-bit totals
    for (int i = 0; i < 4; i++) word_s(0, 8);
    chk("sat_lock", s_lock, 1);
    for (int i = 0; i < 31; i++) word_s(8, 8);
    chk("sat_te31", s_te, 248);
    chk("sat_tb31", s_tb, 248);
    word_s(8, 8);
    chk("sat_te32", s_te, 255);
    chk("sat_tb32", s_tb, 255);
    for (int i = 0; i < 8; i++) word_s(8, 8);
    chk("sat_te_hold", s_te, 255);
    chk("sat_tb_hold", s_tb, 255);
    chk("sat_still_locked", s_lock, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
